// File: rtl/button_pkg.sv
// Shared types and width helpers for the button event conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    StReleased,
    StPressWait,
    StPressed,
    StReleaseWait
  } db_state_e;

  localparam int unsigned DefaultNumCh          = 5;
  localparam int unsigned DefaultDebounceCycles = 250000;
  localparam int unsigned DefaultFifoDepth      = 4;

  // Channel index width; a single channel still needs one bit.
  function automatic int unsigned ch_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles) + 1;
  endfunction

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, debounce FSM with stability counter,
// debounced level and one-cycle press/release pulses.
module debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n_raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned     CntW    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic            sync1;
  logic            sync2;
  logic            s;
  db_state_e       state;
  logic [CntW-1:0] cnt;

  assign s = ~sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1         <= 1'b1;
      sync2         <= 1'b1;
      state         <= StReleased;
      cnt           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync1         <= btn_n_raw;
      sync2         <= sync1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        StReleased: begin
          if (s) begin
            state <= StPressWait;
            cnt   <= CntOne;
          end
        end
        StPressWait: begin
          if (!s) begin
            state <= StReleased;
            cnt   <= '0;
          end else if (cnt == CntLast) begin
            state       <= StPressed;
            cnt         <= '0;
            level       <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CntOne;
          end
        end
        StPressed: begin
          if (!s) begin
            state <= StReleaseWait;
            cnt   <= CntOne;
          end
        end
        StReleaseWait: begin
          if (s) begin
            state <= StPressed;
            cnt   <= '0;
          end else if (cnt == CntLast) begin
            state         <= StReleased;
            cnt           <= '0;
            level         <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CntOne;
          end
        end
        default: begin
          state <= StReleased;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_event_conditioner.sv
// Debounces NUM_CH active-low buttons and queues enabled press events as channel
// indices in a small first-word-fall-through FIFO read with valid/ready.
module button_event_conditioner
  import button_pkg::*;
#(
  parameter  int unsigned NUM_CH          = DefaultNumCh,
  parameter  int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter  int unsigned FIFO_DEPTH      = DefaultFifoDepth,
  localparam int unsigned CH_W            = ch_width(NUM_CH),
  localparam int unsigned OCC_W           = occ_width(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] btn_n_raw,
  input  logic [NUM_CH-1:0] enable_mask,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] release_pulse,
  output logic              evt_valid,
  output logic [CH_W-1:0]   evt_ch,
  input  logic              evt_ready,
  output logic [OCC_W-1:0]  evt_count,
  output logic              overflow,
  input  logic              clear_overflow
);

  localparam int unsigned      PtrW    = $clog2(FIFO_DEPTH);
  localparam logic [PtrW-1:0]  PtrOne  = PtrW'(1);
  localparam logic [OCC_W-1:0] OccFull = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] OccOne  = OCC_W'(1);

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk          (clk),
      .reset        (reset),
      .btn_n_raw    (btn_n_raw[g]),
      .level        (level[g]),
      .press_pulse  (press_pulse[g]),
      .release_pulse(release_pulse[g])
    );
  end

  logic [NUM_CH-1:0] pending_q;
  logic [NUM_CH-1:0] pending_d;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] popped;
  logic [NUM_CH-1:0] press_en;
  logic [NUM_CH-1:0] lost;
  logic [CH_W-1:0]   push_ch;
  logic              req_any;
  logic              push_allowed;
  logic              push;
  logic              pop;
  logic              overflow_d;

  logic [CH_W-1:0]  mem [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [OCC_W-1:0] count_q;

  assign evt_valid = (count_q != '0);
  assign evt_ch    = mem[rd_ptr];
  assign evt_count = count_q;

  assign pop          = evt_valid & evt_ready;
  assign push_allowed = (count_q != OccFull) | pop;
  assign req          = pending_q & enable_mask;
  assign press_en     = press_pulse & enable_mask;

  // Fixed priority: lowest set channel index wins the push slot.
  always_comb begin
    grant   = '0;
    push_ch = '0;
    req_any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req[i] && !req_any) begin
        grant[i] = 1'b1;
        push_ch  = CH_W'(i);
        req_any  = 1'b1;
      end
    end
  end

  assign push   = req_any & push_allowed;
  assign popped = grant & {NUM_CH{push}};

  // A new press only collides with a pending bit that is not leaving this cycle.
  assign lost      = press_en & pending_q & ~popped;
  assign pending_d = ((pending_q & ~popped) | press_en) & enable_mask;

  always_comb begin
    overflow_d = overflow;
    if (|lost) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      overflow  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overflow  <= overflow_d;
    end
  end

  // Popped slots are zeroed so an empty FIFO presents evt_ch = 0; when full with
  // a simultaneous pop and push both hit the same slot and the write wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (pop) begin
        mem[rd_ptr] <= '0;
        rd_ptr      <= rd_ptr + PtrOne;
      end
      if (push) begin
        mem[wr_ptr] <= push_ch;
        wr_ptr      <= wr_ptr + PtrOne;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + OccOne;
        2'b01:   count_q <= count_q - OccOne;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_conditioner.sv
// Directed bench for button_event_conditioner with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
module tb_button_event_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn_n_raw;
  logic [4:0] enable_mask;
  logic [4:0] level;
  logic [4:0] press_pulse;
  logic [4:0] release_pulse;
  logic       evt_valid;
  logic [2:0] evt_ch;
  logic       evt_ready;
  logic [2:0] evt_count;
  logic       overflow;
  logic       clear_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_event_conditioner #(
    .NUM_CH         (5),
    .DEBOUNCE_CYCLES(4),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_n_raw     (btn_n_raw),
    .enable_mask   (enable_mask),
    .level         (level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .evt_valid     (evt_valid),
    .evt_ch        (evt_ch),
    .evt_ready     (evt_ready),
    .evt_count     (evt_count),
    .overflow      (overflow),
    .clear_overflow(clear_overflow)
  );

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wait_edges(3);
    checks++; if (level !== 5'b0) begin errors++; $display("FAIL reset_level got %b want 00000", level); end
    checks++; if (press_pulse !== 5'b0) begin errors++; $display("FAIL reset_press got %b want 00000", press_pulse); end
    checks++; if (release_pulse !== 5'b0) begin errors++; $display("FAIL reset_release got %b want 00000", release_pulse); end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", evt_valid); end
    checks++; if (evt_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", evt_count); end
    checks++; if (evt_ch !== 3'd0) begin errors++; $display("FAIL reset_ch got %0d want 0", evt_ch); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    reset = 1'b0;
    wait_edges(3);
  endtask

  task automatic test_single_press;
    btn_n_raw[2] = 1'b0;
    wait_edges(5);
    checks++; if (press_pulse !== 5'b0) begin errors++; $display("FAIL single_early_press got %b want 00000", press_pulse); end
    checks++; if (level !== 5'b0) begin errors++; $display("FAIL single_early_level got %b want 00000", level); end
    wait_edges(1);
    checks++; if (press_pulse !== 5'b00100) begin errors++; $display("FAIL single_press got %b want 00100", press_pulse); end
    checks++; if (level !== 5'b00100) begin errors++; $display("FAIL single_level got %b want 00100", level); end
    wait_edges(1);
    checks++; if (press_pulse !== 5'b0) begin errors++; $display("FAIL single_pulse_width got %b want 00000", press_pulse); end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early got %b want 0", evt_valid); end
    wait_edges(1);
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", evt_valid); end
    checks++; if (evt_ch !== 3'd2) begin errors++; $display("FAIL single_ch got %0d want 2", evt_ch); end
    checks++; if (evt_count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", evt_count); end
    // Ready held for a second cycle while empty must not underflow.
    evt_ready = 1'b1;
    wait_edges(2);
    evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got %b want 0", evt_valid); end
    checks++; if (evt_count !== 3'd0) begin errors++; $display("FAIL single_pop_count got %0d want 0", evt_count); end
    btn_n_raw[2] = 1'b1;
    wait_edges(6);
    checks++; if (release_pulse !== 5'b00100) begin errors++; $display("FAIL single_release got %b want 00100", release_pulse); end
    checks++; if (level !== 5'b0) begin errors++; $display("FAIL single_release_level got %b want 00000", level); end
    wait_edges(3);
    checks++; if (evt_count !== 3'd0) begin errors++; $display("FAIL single_release_no_evt got %0d want 0", evt_count); end
  endtask

  task automatic test_bounce;
    int n = 0;
    int at = 0;
    logic [3:0] pattern = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      btn_n_raw[1] = pattern[i];
      for (int c = 0; c < 2; c++) begin
        wait_edges(1);
        if (press_pulse[1]) n++;
      end
    end
    btn_n_raw[1] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      wait_edges(1);
      if (press_pulse[1]) begin
        n++;
        if (at == 0) at = i;
      end
    end
    checks++; if (n !== 1) begin errors++; $display("FAIL bounce_pulse_count got %0d want 1", n); end
    checks++; if (at !== 6) begin errors++; $display("FAIL bounce_pulse_cycle got %0d want 6", at); end
    checks++; if (level !== 5'b00010) begin errors++; $display("FAIL bounce_level got %b want 00010", level); end
    checks++; if (evt_ch !== 3'd1) begin errors++; $display("FAIL bounce_ch got %0d want 1", evt_ch); end
    checks++; if (evt_count !== 3'd1) begin errors++; $display("FAIL bounce_count got %0d want 1", evt_count); end
    evt_ready = 1'b1;
    wait_edges(1);
    evt_ready = 1'b0;
    btn_n_raw[1] = 1'b1;
    wait_edges(8);
  endtask

  task automatic test_simultaneous;
    logic [2:0] exp_ch [3] = '{3'd0, 3'd3, 3'd4};
    btn_n_raw = 5'b00110;
    wait_edges(6);
    checks++; if (press_pulse !== 5'b11001) begin errors++; $display("FAIL simul_press got %b want 11001", press_pulse); end
    wait_edges(2);
    checks++; if (evt_count !== 3'd1) begin errors++; $display("FAIL simul_count1 got %0d want 1", evt_count); end
    checks++; if (evt_ch !== 3'd0) begin errors++; $display("FAIL simul_head got %0d want 0", evt_ch); end
    wait_edges(1);
    checks++; if (evt_count !== 3'd2) begin errors++; $display("FAIL simul_count2 got %0d want 2", evt_count); end
    wait_edges(1);
    checks++; if (evt_count !== 3'd3) begin errors++; $display("FAIL simul_count3 got %0d want 3", evt_count); end
    wait_edges(2);
    checks++; if (evt_count !== 3'd3) begin errors++; $display("FAIL simul_count_final got %0d want 3", evt_count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (evt_ch !== exp_ch[i]) begin errors++; $display("FAIL simul_order[%0d] got %0d want %0d", i, evt_ch, exp_ch[i]); end
      evt_ready = 1'b1;
      wait_edges(1);
      evt_ready = 1'b0;
    end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL simul_drained got %b want 0", evt_valid); end
    btn_n_raw = 5'b11111;
    wait_edges(8);
  endtask

  task automatic test_overflow;
    logic [2:0] exp_ch [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    btn_n_raw = 5'b10000;
    wait_edges(12);
    checks++; if (evt_count !== 3'd4) begin errors++; $display("FAIL ovf_full got %0d want 4", evt_count); end
    btn_n_raw[4] = 1'b0;
    wait_edges(8);
    checks++; if (evt_count !== 3'd4) begin errors++; $display("FAIL ovf_wait_count got %0d want 4", evt_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_first_press got %b want 0", overflow); end
    btn_n_raw[4] = 1'b1;
    wait_edges(8);
    btn_n_raw[4] = 1'b0;
    wait_edges(6);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before_loss got %b want 0", overflow); end
    wait_edges(1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_loss got %b want 1", overflow); end
    evt_ready = 1'b1;
    wait_edges(1);
    evt_ready = 1'b0;
    checks++; if (evt_count !== 3'd4) begin errors++; $display("FAIL ovf_pop_push_count got %0d want 4", evt_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    clear_overflow = 1'b1;
    wait_edges(1);
    clear_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (evt_ch !== exp_ch[i]) begin errors++; $display("FAIL ovf_order[%0d] got %0d want %0d", i, evt_ch, exp_ch[i]); end
      evt_ready = 1'b1;
      wait_edges(1);
      evt_ready = 1'b0;
    end
    checks++; if (evt_count !== 3'd0) begin errors++; $display("FAIL ovf_drained got %0d want 0", evt_count); end
    btn_n_raw = 5'b11111;
    wait_edges(8);
  endtask

  task automatic test_mask;
    enable_mask = 5'b10111;
    btn_n_raw[3] = 1'b0;
    wait_edges(6);
    checks++; if (press_pulse !== 5'b01000) begin errors++; $display("FAIL mask_press got %b want 01000", press_pulse); end
    checks++; if (level !== 5'b01000) begin errors++; $display("FAIL mask_level got %b want 01000", level); end
    wait_edges(3);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL mask_no_evt got %b want 0", evt_valid); end
    enable_mask = 5'b11111;
    btn_n_raw = 5'b11111;
    wait_edges(8);
  endtask

  task automatic test_reset_mid;
    btn_n_raw = 5'b11100;
    wait_edges(9);
    checks++; if (evt_count !== 3'd2) begin errors++; $display("FAIL rmid_queued got %0d want 2", evt_count); end
    btn_n_raw = 5'b11000;
    wait_edges(3);
    reset = 1'b1;
    wait_edges(1);
    reset = 1'b0;
    checks++; if (level !== 5'b0) begin errors++; $display("FAIL rmid_level got %b want 00000", level); end
    checks++; if (evt_count !== 3'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", evt_count); end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", evt_valid); end
    checks++; if (evt_ch !== 3'd0) begin errors++; $display("FAIL rmid_ch got %0d want 0", evt_ch); end
    wait_edges(5);
    checks++; if (press_pulse !== 5'b0) begin errors++; $display("FAIL rmid_early got %b want 00000", press_pulse); end
    wait_edges(1);
    checks++; if (press_pulse !== 5'b00111) begin errors++; $display("FAIL rmid_repress got %b want 00111", press_pulse); end
    checks++; if (level !== 5'b00111) begin errors++; $display("FAIL rmid_relevel got %b want 00111", level); end
  endtask

  initial begin
    reset          = 1'b1;
    btn_n_raw      = 5'b11111;
    enable_mask    = 5'b11111;
    evt_ready      = 1'b0;
    clear_overflow = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_overflow();
    test_mask();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
